wide_queue: RTL and testbench

WIDE_QUEUE -- requirements
Module: wide_queue

---
 rtl/wide_queue.sv | 89 ++++++++
 tb/tb_wide_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wide_queue.sv
// Multi-lane circular queue: up to LANES entries enqueued and dequeued per cycle.
// Dequeue is zero-latency; enqueue is all-or-nothing against pre-cycle occupancy.
module wide_queue #(
  parameter int unsigned LENGTH    = 8,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LANES     = 2,
  parameter int unsigned INIT      = 0,
  parameter int unsigned INIT_BASE = 32,
  parameter int unsigned KEEP_HEAD = 0,
  localparam int unsigned NW = $clog2(LANES + 1),
  localparam int unsigned PW = $clog2(LENGTH),
  localparam int unsigned CW = $clog2(LENGTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [NW-1:0]          enq_num,
  input  logic [LANES*WIDTH-1:0] enq_data,
  input  logic [NW-1:0]          deq_num,
  output logic [LANES*WIDTH-1:0] deq_data,
  output logic [LANES-1:0]       deq_valid,
  output logic [CW-1:0]          count,
  output logic                   halt
);

  logic [WIDTH-1:0] mem_q [LENGTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic [NW-1:0]    deq_grant;
  logic             enq_accept;

  always_comb begin
    deq_grant = '0;
    if (!reset && !stall && !flush && 32'(deq_num) <= LANES) begin
      deq_grant = (32'(deq_num) <= 32'(count_q)) ? deq_num : NW'(count_q);
    end
  end

  // Space is judged on the pre-cycle count; a same-cycle dequeue frees nothing.
  assign enq_accept = !reset && !flush && 32'(enq_num) <= LANES &&
                      32'(enq_num) <= LENGTH - 32'(count_q);

  always_comb begin
    deq_valid = '0;
    deq_data  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (32'(deq_grant) > 32'(k)) begin
        deq_valid[k]               = 1'b1;
        deq_data[k*WIDTH +: WIDTH] = mem_q[head_q + PW'(k)];
      end
    end
  end

  assign count = count_q;
  assign halt  = (INIT != 0) ? (32'(count_q) < LANES) : (LENGTH - 32'(count_q) < LANES);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= (INIT != 0) ? CW'(LENGTH) : '0;
      for (int i = 0; i < LENGTH; i++) begin
        mem_q[i] <= (INIT != 0) ? WIDTH'(INIT_BASE + 32'(i)) : '0;
      end
    end else if (flush) begin
      if (KEEP_HEAD != 0 && count_q != '0) begin
        tail_q  <= head_q + PW'(1);
        count_q <= CW'(1);
      end else begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end
    end else begin
      head_q <= head_q + PW'(deq_grant);
      if (enq_accept) begin
        for (int k = 0; k < LANES; k++) begin
          if (32'(k) < 32'(enq_num)) begin
            mem_q[tail_q + PW'(k)] <= enq_data[k*WIDTH +: WIDTH];
          end
        end
        tail_q <= tail_q + PW'(enq_num);
      end
      count_q <= count_q + (enq_accept ? CW'(enq_num) : '0) - CW'(deq_grant);
    end
  end

endmodule

// File: tb/tb_wide_queue.sv
// Bench for wide_queue: three configurations (plain, INIT=1, KEEP_HEAD=1) share stimulus,
// each checked against an ordered-list model of its contents.
module tb_wide_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [1:0]  enq_num = '0, deq_num = '0;
  logic [63:0] enq_data = '0;

  logic [63:0] dq_data  [3];
  logic [1:0]  dq_valid [3];
  logic [3:0]  dq_count [3];
  logic        dq_halt  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wide_queue #(.LENGTH(8), .WIDTH(32), .LANES(2), .INIT(0), .INIT_BASE(32), .KEEP_HEAD(0)) u_plain (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .enq_num(enq_num),
    .enq_data(enq_data), .deq_num(deq_num), .deq_data(dq_data[0]), .deq_valid(dq_valid[0]),
    .count(dq_count[0]), .halt(dq_halt[0]));

  wide_queue #(.LENGTH(8), .WIDTH(32), .LANES(2), .INIT(1), .INIT_BASE(32), .KEEP_HEAD(0)) u_init (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .enq_num(enq_num),
    .enq_data(enq_data), .deq_num(deq_num), .deq_data(dq_data[1]), .deq_valid(dq_valid[1]),
    .count(dq_count[1]), .halt(dq_halt[1]));

  wide_queue #(.LENGTH(8), .WIDTH(32), .LANES(2), .INIT(0), .INIT_BASE(32), .KEEP_HEAD(1)) u_keep (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .enq_num(enq_num),
    .enq_data(enq_data), .deq_num(deq_num), .deq_data(dq_data[2]), .deq_valid(dq_valid[2]),
    .count(dq_count[2]), .halt(dq_halt[2]));

  // Model: mdata[i][0] is the oldest entry of instance i, mcnt[i] the occupancy.
  logic [31:0] mdata [3][8];
  int          mcnt  [3];
  int          minit [3] = '{0, 1, 0};
  int          mkeep [3] = '{0, 0, 1};
  bit          live = 1'b0;
  logic [31:0] seq = 32'hA000_0000;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, advance the model.
  task automatic step(input logic rst, input logic st, input logic fl, input int en,
                      input logic [31:0] d0, input logic [31:0] d1, input int dn);
    int g;
    int pre;
    logic [1:0]  ev;
    logic [63:0] ed;
    @(negedge clk);
    reset = rst; stall = st; flush = fl;
    enq_num = 2'(en); deq_num = 2'(dn); enq_data = {d1, d0};
    #1;
    for (int i = 0; i < 3; i++) begin
      g = (rst || st || fl || dn > 2) ? 0 : ((dn < mcnt[i]) ? dn : mcnt[i]);
      ev = '0;
      ed = '0;
      for (int k = 0; k < 2; k++) begin
        if (k < g) begin
          ev[k] = 1'b1;
          ed[k*32 +: 32] = mdata[i][k];
        end
      end
      check_eq($sformatf("u%0d_deq_valid", i), 64'(dq_valid[i]), 64'(ev));
      check_eq($sformatf("u%0d_deq_data", i), dq_data[i], ed);
      if (live) begin
        check_eq($sformatf("u%0d_count", i), 64'(dq_count[i]), 64'(mcnt[i]));
        check_eq($sformatf("u%0d_halt", i), 64'(dq_halt[i]),
                 64'((minit[i] != 0) ? (mcnt[i] < 2) : (8 - mcnt[i] < 2)));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      g = (rst || st || fl || dn > 2) ? 0 : ((dn < mcnt[i]) ? dn : mcnt[i]);
      if (rst) begin
        mcnt[i] = (minit[i] != 0) ? 8 : 0;
        for (int j = 0; j < 8; j++) mdata[i][j] = (minit[i] != 0) ? 32'(32 + j) : '0;
      end else if (fl) begin
        mcnt[i] = (mkeep[i] != 0 && mcnt[i] > 0) ? 1 : 0;
      end else begin
        pre = mcnt[i];
        for (int j = 0; j < 8 - g; j++) mdata[i][j] = mdata[i][j+g];
        mcnt[i] = mcnt[i] - g;
        if (en <= 2 && en <= 8 - pre) begin
          if (en >= 1) mdata[i][mcnt[i]]   = d0;
          if (en >= 2) mdata[i][mcnt[i]+1] = d1;
          mcnt[i] = mcnt[i] + en;
        end
      end
    end
    if (rst) live = 1'b1;
  endtask

  task automatic enq(input int n);
    step(1'b0, 1'b0, 1'b0, n, seq, seq + 1, 0);
    seq = seq + 2;
  endtask

  task automatic deq(input int n);
    step(1'b0, 1'b0, 1'b0, 0, '0, '0, n);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 0, '0, '0, 0);
  endtask

  initial begin
    do_reset();
    do_reset();

    // Fill to full, then an over-capacity request must be refused.
    for (int c = 0; c < 4; c++) enq(2);
    #1;
    check_eq("fill_count", 64'(dq_count[0]), 64'd8);
    check_eq("fill_halt", 64'(dq_halt[0]), 64'd1);
    enq(1);
    #1;
    check_eq("full_reject_count", 64'(dq_count[0]), 64'd8);
    // Full queue: dequeue granted, enqueue refused.
    step(1'b0, 1'b0, 1'b0, 2, 32'hDEAD_0001, 32'hDEAD_0002, 2);
    #1;
    check_eq("full_enq_deq_count", 64'(dq_count[0]), 64'd6);

    // Wrap-around across slot 7 -> 0.
    do_reset();
    enq(2); enq(2); enq(2); enq(1);
    deq(2); deq(2); deq(2);
    enq(2); enq(2);
    #1;
    check_eq("wrap_count", 64'(dq_count[0]), 64'd5);
    deq(2); deq(2); deq(2);

    // Single entry: stall blocks, then a partial grant.
    do_reset();
    enq(1);
    step(1'b0, 1'b1, 1'b0, 0, '0, '0, 2);
    #1;
    check_eq("stall_count", 64'(dq_count[0]), 64'd1);
    deq(2);
    #1;
    check_eq("partial_count", 64'(dq_count[0]), 64'd0);

    // INIT=1 instance: preload dequeue then refill.
    do_reset();
    deq(2);
    #1;
    check_eq("init_count", 64'(dq_count[1]), 64'd6);
    step(1'b0, 1'b0, 1'b0, 1, 32'd40, 32'd0, 0);
    deq(2); deq(2); deq(2); deq(2);

    // KEEP_HEAD flush at head=3, count=5 with competing requests.
    do_reset();
    enq(2); enq(2); deq(2); deq(1); enq(2); enq(2);
    step(1'b0, 1'b0, 1'b1, 2, 32'hF1, 32'hF2, 2);
    #1;
    check_eq("keep_flush_count", 64'(dq_count[2]), 64'd1);
    check_eq("plain_flush_count", 64'(dq_count[0]), 64'd0);
    deq(1);
    enq(2); deq(2); deq(2);

    // Randomized traffic, including illegal lane counts, stalls, flushes and resets.
    for (int c = 0; c < 1500; c++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(15) == 0),
           $urandom_range(3), $urandom, $urandom, $urandom_range(3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
